// File: rtl/morse_key_packetizer.sv
// Morse key packetizer: turns a raw Morse key and a raw "back" button into
// 11-bit key packets {3'b001, code}. Codes: 1 = DOT, 2 = DASH, 11 = BACK.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       high = packet generation allowed
//   key_in       raw Morse key (asynchronous, high = pressed)
//   back_in      raw back button (asynchronous, high = pressed)
//   dash_cycles  press length at or above which a press is a DASH
//   key_packet   {type, code}; holds its last value while key_valid is low
//   key_valid    one-cycle strobe qualifying key_packet
//   key_pressed  debounced key level
module morse_key_packetizer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_in,
  input  logic        back_in,
  input  logic [31:0] dash_cycles,
  output logic [10:0] key_packet,
  output logic        key_valid,
  output logic        key_pressed
);

  localparam logic [2:0] PktType  = 3'b001;
  localparam logic [7:0] CodeDot  = 8'd1;
  localparam logic [7:0] CodeDash = 8'd2;
  localparam logic [7:0] CodeBack = 8'd11;

  typedef enum logic [1:0] {StIdle, StPress, StEmit} state_e;

  logic        key_s1_q, key_s2_q, back_s1_q, back_s2_q;
  logic        key_db_q, key_db_d, back_db_q, back_db_d, back_prev_q;
  logic [31:0] key_cnt_q, key_cnt_d, back_cnt_q, back_cnt_d;
  logic        key_flip, back_flip;
  logic        key_rise, key_fall, back_rise;

  state_e      state_q;
  logic [31:0] press_cnt_q;
  logic        pend_q;
  logic        valid_q;
  logic [10:0] packet_q;

  // Debouncers: the level flips on the cycle the mismatch count reaches
  // DEBOUNCE_CYCLES; any agreeing cycle clears the count.
  always_comb begin
    key_flip  = 1'b0;
    key_db_d  = key_db_q;
    key_cnt_d = '0;
    if (key_s2_q != key_db_q) begin
      if (key_cnt_q + 32'd1 == DEBOUNCE_CYCLES) begin
        key_flip = 1'b1;
        key_db_d = ~key_db_q;
      end else begin
        key_cnt_d = key_cnt_q + 32'd1;
      end
    end

    back_flip  = 1'b0;
    back_db_d  = back_db_q;
    back_cnt_d = '0;
    if (back_s2_q != back_db_q) begin
      if (back_cnt_q + 32'd1 == DEBOUNCE_CYCLES) begin
        back_flip = 1'b1;
        back_db_d = ~back_db_q;
      end else begin
        back_cnt_d = back_cnt_q + 32'd1;
      end
    end
  end

  // The key FSM reacts on the flip edge itself, so EMIT coincides with the
  // cycle the debounced key reads low. The back edge is taken from the
  // registered level so a simultaneous back event lands in that same cycle.
  assign key_rise  = key_flip & ~key_db_q;
  assign key_fall  = key_flip & key_db_q;
  assign back_rise = back_db_q & ~back_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      back_s1_q  <= 1'b0;
      back_s2_q  <= 1'b0;
      key_db_q   <= 1'b0;
      back_db_q  <= 1'b0;
      key_cnt_q  <= '0;
      back_cnt_q <= '0;
    end else begin
      key_s1_q   <= key_in;
      key_s2_q   <= key_s1_q;
      back_s1_q  <= back_in;
      back_s2_q  <= back_s1_q;
      key_db_q   <= key_db_d;
      back_db_q  <= back_db_d;
      key_cnt_q  <= key_cnt_d;
      back_cnt_q <= back_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      press_cnt_q <= '0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      packet_q    <= '0;
      back_prev_q <= 1'b0;
    end else begin
      // Track the back level even while disabled so a button held across
      // enable rising does not look like a new press.
      back_prev_q <= back_db_q;
      if (!enable) begin
        state_q     <= StIdle;
        press_cnt_q <= '0;
        pend_q      <= 1'b0;
        valid_q     <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (key_rise) begin
              state_q     <= StPress;
              press_cnt_q <= 32'd1;
            end
          end
          StPress: begin
            if (key_fall) begin
              state_q <= StEmit;
            end else if (press_cnt_q != 32'hFFFF_FFFF) begin
              press_cnt_q <= press_cnt_q + 32'd1;
            end
          end
          StEmit: begin
            // With very short debounce a new press can begin during EMIT.
            if (key_rise) begin
              state_q     <= StPress;
              press_cnt_q <= 32'd1;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase

        // DOT/DASH wins a tie; a concurrent BACK waits one cycle in pend_q.
        if (state_q == StEmit) begin
          valid_q  <= 1'b1;
          packet_q <= {PktType, (press_cnt_q < dash_cycles) ? CodeDot : CodeDash};
          pend_q   <= back_rise | pend_q;
        end else if (back_rise || pend_q) begin
          valid_q  <= 1'b1;
          packet_q <= {PktType, CodeBack};
          pend_q   <= 1'b0;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign key_packet  = packet_q;
  assign key_valid   = valid_q;
  assign key_pressed = key_db_q;

endmodule

// File: doc/morse_key_packetizer.md
MORSE_KEY_PACKETIZER -- requirements
Module: morse_key_packetizer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst SHALL be the only clock and reset ports.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive cycles a synchronized input must differ from its debounced level before that level flips; legal range >= 1.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 enable  input  1  high = packet generation allowed.
REQ-006 key_in  input  1  raw Morse key, asynchronous, high = pressed.
REQ-007 back_in  input  1  raw back button, asynchronous, high = pressed.
REQ-008 dash_cycles  input  32  press-length threshold: presses at or above this length are dashes.
REQ-009 key_packet  output  11  {type[2:0], code[7:0]}; type is always 3'b001.
REQ-010 key_valid  output  1  one-cycle strobe qualifying key_packet; there is no backpressure.
REQ-011 key_pressed  output  1  debounced key level for LED or buzzer.

Function
REQ-012 key_in and back_in SHALL each pass through a 2-flop synchronizer and then an independent debouncer.
REQ-013 Debouncer behaviour:
- A per-input counter increments while the synchronized value differs from the debounced level.
- The counter clears on any cycle the two agree.
- The debounced level flips on the cycle the counter reaches DEBOUNCE_CYCLES; the counter then clears.
REQ-014 Latency from a clean raw edge to a debounced change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-015 The key state machine SHALL have states IDLE, PRESS and EMIT.
- IDLE -> PRESS on a debounced key rising edge; press_cnt loads 1.
- PRESS: press_cnt increments each cycle and saturates at 32'hFFFF_FFFF.
- PRESS -> EMIT on a debounced key falling edge.
- EMIT -> IDLE unconditionally after one cycle.
REQ-016 In EMIT the block SHALL output code 8'd1 (DOT) if press_cnt < dash_cycles, else 8'd2 (DASH).
- dash_cycles is sampled in the EMIT cycle.
- dash_cycles = 0 makes every press a DASH.
REQ-017 A debounced back rising edge SHALL produce code 8'd11 (BACK). Falling edges and a held button produce nothing further.
REQ-018 key_packet and key_valid SHALL be registered, asserting the cycle after EMIT or the back edge.
- key_valid is high for exactly one cycle per packet.
- key_packet holds its last value while key_valid is low.
REQ-019 At most one packet SHALL be issued per cycle. If a DOT/DASH and a BACK become due in the same cycle:
- DOT/DASH is issued first.
- BACK is held in a 1-entry pending flag and issued the next cycle.
REQ-020 When enable is low:
- No packets are issued and the pending flag is cleared.
- The state machine is forced to IDLE and press_cnt cleared; a press in progress is discarded.
- Debouncers keep running and key_pressed stays live.
REQ-021 When enable rises while the debounced key is already high, the block SHALL NOT start PRESS until the next debounced rising edge.

Reset
REQ-022 On rst high at a clock edge, all of the following SHALL clear to 0 on that edge:
- synchronizer flops, debounced levels and debounce counters;
- state (IDLE), press_cnt and the pending flag;
- key_valid, key_pressed and key_packet.
REQ-023 Reset asserted mid-press SHALL discard the press with no packet issued. A key held through reset release SHALL register as a new press after 2 + DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES = 4, dash_cycles = 20, enable = 1 unless stated)
REQ-024 Press key_in for 10 cycles, clean -> key_pressed rises 6 cycles after the edge; one key_valid with key_packet = 11'h101.
REQ-025 Press key_in for 40 cycles -> one key_valid with key_packet = 11'h102; set dash_cycles = 0 with a 5-cycle press -> 11'h102.
REQ-026 Toggle key_in every cycle for 30 cycles, then hold low -> key_pressed stays 0 and no key_valid.
REQ-027 Release key_in and press back_in so both debounced events fall on the same cycle -> 11'h102 on cycle N and 11'h10B on cycle N+1; key_valid high on both cycles.
REQ-028 Hold back_in high for 100 cycles -> exactly one 11'h10B; drop enable mid key press then release -> no packet.
REQ-029 Assert rst for 1 cycle mid key press -> all outputs 0 the next cycle and no packet for that press.
